axi_buffer_fifo: RTL and testbench

- Valid/ready FIFO that sits directly downstream of the random-delay handshake stage in the Versat AXI test path.
- Absorbs the bursty stalls injected upstream and re-presents data with registered output control.
- Breaks the combinational ready path between the producer and the consumer.
- Carries a data payload alongside the handshake, which the delay stage does not.

---
 rtl/axi_buffer_fifo_pkg.sv | 17 +
 rtl/axi_buffer_fifo_mem.sv | 32 +++
 rtl/axi_buffer_fifo.sv | 131 +++++++++++++
 tb/tb_axi_buffer_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_buffer_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_buffer_fifo_pkg
// Description : Shared width helpers and constants for the AXI buffer FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_buffer_fifo_pkg;

  localparam int AXI_BUF_STAT_W = 32;

  // Occupancy needs one bit more than the pointers so full and empty differ.
  function automatic int axi_buf_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_buffer_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi_buffer_mem
// Description : DEPTH x DATA_W register file, one synchronous write port and
//               one asynchronous read port, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_buffer_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/axi_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axi_buffer_fifo
// Description : Valid/ready FIFO with registered s_ready, m_valid and level.
//               Optional statistics outputs under AXI_BUFFER_FIFO_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_buffer_fifo
  import axi_buffer_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int LVL_W = axi_buf_lvl_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [LVL_W-1:0]  level
`ifdef AXI_BUFFER_FIFO_STATS_EN
  ,
  output logic [LVL_W-1:0]          max_level,
  output logic [AXI_BUF_STAT_W-1:0] stall_cycles
`endif
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;

  logic push;
  logic pop;
  logic mem_we;

  // Handshakes only see registered flags, so m_ready never reaches s_ready.
  assign push   = s_valid && s_ready_q;
  assign pop    = m_valid_q && m_ready;
  assign mem_we = push && rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    s_ready_d = (count_d != FULL_LVL);
    m_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  axi_buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (s_data),
    .raddr (rd_ptr_q),
    .rdata (m_data)
  );

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign level   = count_q;

`ifdef AXI_BUFFER_FIFO_STATS_EN
  logic [LVL_W-1:0]          max_level_q, max_level_d;
  logic [AXI_BUF_STAT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    max_level_d    = max_level_q;
    stall_cycles_d = stall_cycles_q;
    if (count_d > max_level_q) begin
      max_level_d = count_d;
    end
    // Saturate rather than wrap so a long stall never reads as a short one.
    if (m_valid_q && !m_ready && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      max_level_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      max_level_q    <= max_level_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign max_level    = max_level_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_buffer_fifo
// Description : Self-checking bench for axi_buffer_fifo: queue-based model,
//               per-cycle compare, directed and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_buffer_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              s_valid = 1'b0;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  wire               s_ready;
  wire               m_valid;
  wire [DATA_W-1:0]  m_data;
  wire [LVL_W-1:0]   level;
`ifdef AXI_BUFFER_FIFO_STATS_EN
  wire [LVL_W-1:0]   max_level;
  wire [31:0]        stall_cycles;
`endif

  axi_buffer_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .level        (level)
`ifdef AXI_BUFFER_FIFO_STATS_EN
    ,
    .max_level    (max_level),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endfunction

  // Behavioural model: a queue of buffered words plus the registered flags.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] out_log[$];
  bit                e_s_ready = 1'b0;
  bit                e_m_valid = 1'b0;
  int                e_max = 0;
  longint            e_stall = 0;
  bit                last_push = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      e_s_ready = 1'b0;
      e_m_valid = 1'b0;
      e_max     = 0;
      e_stall   = 0;
      last_push = 1'b0;
    end else begin
      last_push = s_valid && e_s_ready;
      if (e_m_valid && !m_ready && e_stall < 64'hFFFF_FFFF) e_stall++;
      if (e_m_valid && m_ready) out_log.push_back(q.pop_front());
      if (last_push) q.push_back(s_data);
      if (q.size() > e_max) e_max = q.size();
      e_s_ready = (q.size() != DEPTH);
      e_m_valid = (q.size() != 0);
    end
  end

  // Per-cycle comparison on the falling edge.
  bit                hold_pending = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;

  always @(negedge clk) begin
    chk("s_ready", 64'(s_ready), 64'(e_s_ready));
    chk("m_valid", 64'(m_valid), 64'(e_m_valid));
    chk("level", 64'(level), 64'(q.size()));
    if (e_m_valid) chk("m_data", 64'(m_data), 64'(q[0]));
`ifdef AXI_BUFFER_FIFO_STATS_EN
    chk("max_level", 64'(max_level), 64'(e_max));
    chk("stall_cycles", 64'(stall_cycles), 64'(e_stall));
`endif
    if (hold_pending) chk("m_data_hold", 64'(m_data), 64'(hold_data));
    hold_pending = rst && m_valid && !m_ready;
    hold_data    = m_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] sent[$];

  initial begin
    // Reset held with s_valid asserted.
    rst = 1'b0; s_valid = 1'b1; s_data = 32'hDEAD; m_ready = 1'b0;
    repeat (3) begin
      step();
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
    end
    rst = 1'b1;
    step();
    chk("rel_s_ready", 64'(s_ready), 64'd1);
    chk("rel_level", 64'(level), 64'd0);
    chk("rel_model_empty", 64'(q.size()), 64'd0);
    s_valid = 1'b0;

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'hA0 + 32'(i);
      step();
      chk("fill_level", 64'(level), 64'(i + 1));
    end
    chk("full_s_ready", 64'(s_ready), 64'd0);
    s_data = 32'hA4;
    step();
    chk("pending_level", 64'(level), 64'd4);
    chk("full_m_data", 64'(m_data), 64'hA0);
    repeat (10) step();
`ifdef AXI_BUFFER_FIFO_STATS_EN
    chk("lit_max_level", 64'(max_level), 64'd4);
    chk("lit_stall", 64'(stall_cycles), 64'd14);
`endif

    // One pop from full; s_ready only returns on the following cycle.
    out_log.delete();
    m_ready = 1'b1;
    step();
    chk("pop_s_ready", 64'(s_ready), 64'd1);
    chk("pop_level", 64'(level), 64'd3);
    m_ready = 1'b0;
    step();
    chk("a4_level", 64'(level), 64'd4);
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (4) step();
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_count", 64'(out_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < out_log.size(); i++)
      chk("drain_order", 64'(out_log[i]), 64'(32'hA0 + 32'(i)));

    // Continuous streaming, pointers wrap several times.
    out_log.delete();
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 32'(i);
      step();
      chk("stream_level", 64'(level), 64'd1);
    end
    s_valid = 1'b0;
    step();
    chk("stream_count", 64'(out_log.size()), 64'd16);
    for (int i = 0; i < 16 && i < out_log.size(); i++)
      chk("stream_order", 64'(out_log[i]), 64'(i));

    // Randomized gaps (0..3) upstream and random backpressure downstream.
    out_log.delete();
    sent.delete();
    for (int b = 0; b < 200; b++) begin
      int gap;
      int guard;
      gap = $urandom_range(0, 3);
      s_valid = 1'b0;
      repeat (gap) begin
        m_ready = 1'($urandom);
        step();
      end
      s_valid = 1'b1;
      s_data  = $urandom;
      sent.push_back(s_data);
      guard = 0;
      do begin
        m_ready = 1'($urandom);
        step();
        guard++;
      end while (!last_push && guard < 200);
      if (!last_push) begin
        chk("accept_timeout", 64'(guard), 64'd0);
        break;
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int g = 0; g < 50 && out_log.size() < sent.size(); g++) step();
    chk("rand_count", 64'(out_log.size()), 64'(sent.size()));
    for (int i = 0; i < sent.size() && i < out_log.size(); i++)
      chk("rand_order", 64'(out_log[i]), 64'(sent[i]));

    // Mid-run reset with entries buffered.
    m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h55;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
`ifdef AXI_BUFFER_FIFO_STATS_EN
    chk("midrst_max", 64'(max_level), 64'd0);
    chk("midrst_stall", 64'(stall_cycles), 64'd0);
`endif
    rst = 1'b1; s_valid = 1'b0;
    repeat (3) step();
    chk("post_rst_level", 64'(level), 64'd0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
